// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and default line parameters
// for the receiver and its transmitter partner.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int CLK_FRQ_DEF   = 100_000_000;
  localparam int BAUD_RATE_DEF = 9600;

endpackage : uart_pkg

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input; the reset value
// is a parameter so idle-high and idle-low lines can both use it.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule : uart_sync2

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start-edge detect, mid-bit sampling, LSB-first shift,
// single-cycle data-valid and framing-error strobes.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FRQ   = CLK_FRQ_DEF,
  parameter int BAUD_RATE = BAUD_RATE_DEF,
  parameter int BIT_TIK   = CLK_FRQ / BAUD_RATE,
  parameter int HALF_TIK  = BIT_TIK / 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       frame_err
);

  localparam logic [15:0] HALF_M1 = 16'(HALF_TIK - 1);
  localparam logic [15:0] BIT_M1  = 16'(BIT_TIK - 1);

  logic        rx_s;
  logic        rx_d_q;
  uart_state_e state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;
  logic        busy_q, busy_d;
  logic [1:0]  settle_q, settle_d;
  logic        armed_q, armed_d;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rx),
    .q_o (rx_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_d_q   <= 1'b1;
      state_q  <= IDLE;
      baud_q   <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
      busy_q   <= 1'b0;
      settle_q <= '0;
      armed_q  <= 1'b0;
    end else begin
      rx_d_q   <= rx_s;
      state_q  <= state_d;
      baud_q   <= baud_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      ferr_q   <= ferr_d;
      busy_q   <= busy_d;
      settle_q <= settle_d;
      armed_q  <= armed_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    ferr_d   = 1'b0;
    busy_d   = busy_q;
    settle_d = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;
    // The synchronizer's reset value is not a real line level: only arm edge
    // detection once the line has genuinely been seen high after reset.
    armed_d  = armed_q | ((settle_q == 2'd3) && rx_s);

    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (armed_q && rx_d_q && !rx_s) begin
          baud_d  = '0;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (baud_q == HALF_M1) begin
          baud_d  = '0;
          state_d = rx_s ? IDLE : DATA;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      DATA: begin
        if (baud_q == BIT_M1) begin
          baud_d  = '0;
          shift_d = {rx_s, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = STOP;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      STOP: begin
        if (baud_q == BIT_M1) begin
          baud_d  = '0;
          state_d = IDLE;
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign rx_busy   = busy_q;
  assign frame_err = ferr_q;

endmodule : uart_rx
